// File: rtl/accel_spi_slave.sv
// SPI slave (CPOL=0, CPHA=0, MSB first) with a memory-mapped CPU register port.
// All SPI pins are oversampled in the clk domain; SCLK is never used as a clock.
module accel_spi_slave #(
  parameter int                  DATABITS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [DATABITS-1:0] TX_DEFAULT  = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  input  logic        read_n,
  input  logic        write_n,
  input  logic        spi_select,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int            CW   = $clog2(DATABITS + 1);
  localparam logic [CW-1:0] LAST = CW'(DATABITS - 1);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic                   sclk_dly_q, ss_dly_q;
  logic                   sclk_s, ss_s, mosi_s, ss_act;
  logic                   sclk_rise, sclk_fall, ss_fall, ss_rise;

  logic [DATABITS-1:0] tx_shift_q, tx_shift_d, tx_holding_q, tx_holding_d;
  logic [DATABITS-1:0] rx_shift_q, rx_shift_d, rx_holding_q, rx_holding_d, rx_next;
  logic [CW-1:0]       bitcnt_q, bitcnt_d;
  logic                tx_primed_q, tx_primed_d;
  logic                roe_q, roe_d, toe_q, toe_d, tue_q, tue_d, rrdy_q, rrdy_d;
  logic [5:0]          ctrl_q, ctrl_d;
  logic                rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;
  logic [15:0]         data_to_cpu_q, data_to_cpu_d;
  logic                irq_q, irq_d;

  logic        rd_req, wr_req, trdy, err, load, frame_done;
  logic [15:0] status_w, ctrl_w, rx_w, rd_mux;
  logic        unused_bits;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign ss_s      = ss_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign ss_act    = ~ss_s;
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_dly_q  <= 1'b0;
      ss_dly_q    <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SS_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
      sclk_dly_q  <= sclk_s;
      ss_dly_q    <= ss_s;
    end
  end

  assign trdy       = ~tx_primed_q;
  assign err        = roe_q | toe_q | tue_q;
  assign status_w   = {6'b0, ss_act, err, rrdy_q, trdy, tue_q, toe_q, roe_q, 3'b0};
  assign ctrl_w     = {7'b0, ctrl_q, 3'b0};
  assign rx_w       = 16'(rx_holding_q);
  assign rd_req     = spi_select & ~read_n;
  assign wr_req     = spi_select & ~write_n;
  assign rx_next    = DATABITS'({rx_shift_q, mosi_s});
  assign frame_done = sclk_rise & ss_act & (bitcnt_q == LAST);
  // Shift register reloads at frame start and back-to-back at every frame end.
  assign load       = ss_fall | frame_done;
  assign unused_bits = ^data_from_cpu;

  always_comb begin
    rd_mux = 16'h0000;
    case (mem_addr)
      3'd0:    rd_mux = rx_w;
      3'd2:    rd_mux = status_w;
      3'd3:    rd_mux = ctrl_w;
      default: rd_mux = 16'h0000;
    endcase
  end

  always_comb begin
    tx_shift_d    = tx_shift_q;
    tx_holding_d  = tx_holding_q;
    tx_primed_d   = tx_primed_q;
    rx_shift_d    = rx_shift_q;
    rx_holding_d  = rx_holding_q;
    bitcnt_d      = bitcnt_q;
    roe_d         = roe_q;
    toe_d         = toe_q;
    tue_d         = tue_q;
    rrdy_d        = rrdy_q;
    ctrl_d        = ctrl_q;
    rd_strobe_d   = rd_req & ~rd_strobe_q;
    wr_strobe_d   = wr_req & ~wr_strobe_q;
    data_to_cpu_d = (rd_req & ~rd_strobe_q) ? rd_mux : data_to_cpu_q;

    // CPU clears first so that same-cycle hardware sets below take priority.
    if (rd_strobe_q && mem_addr == 3'd0) rrdy_d = 1'b0;
    if (wr_strobe_q && mem_addr == 3'd2) begin
      roe_d = 1'b0;
      toe_d = 1'b0;
      tue_d = 1'b0;
    end
    if (wr_strobe_q && mem_addr == 3'd3) ctrl_d = data_from_cpu[8:3];

    if (load) begin
      if (tx_primed_q) begin
        tx_shift_d  = tx_holding_q;
        tx_primed_d = 1'b0;
      end else begin
        tx_shift_d = TX_DEFAULT;
        tue_d      = 1'b1;
      end
    end else if (sclk_fall && ss_act && bitcnt_q != '0) begin
      tx_shift_d = tx_shift_q << 1;
    end

    if (wr_strobe_q && mem_addr == 3'd1) begin
      if (!tx_primed_q || load) begin
        tx_holding_d = data_from_cpu[DATABITS-1:0];
        tx_primed_d  = 1'b1;
      end else begin
        toe_d = 1'b1;
      end
    end

    if (ss_rise) begin
      bitcnt_d = '0;
    end else if (sclk_rise && ss_act) begin
      rx_shift_d = rx_next;
      if (bitcnt_q == LAST) begin
        bitcnt_d     = '0;
        rx_holding_d = rx_next;
        rrdy_d       = 1'b1;
        if (rrdy_q) roe_d = 1'b1;
      end else begin
        bitcnt_d = bitcnt_q + 1'b1;
      end
    end

    irq_d = (roe_q & ctrl_q[0]) | (toe_q & ctrl_q[1]) | (tue_q & ctrl_q[2]) |
            (trdy & ctrl_q[3]) | (rrdy_q & ctrl_q[4]) | (err & ctrl_q[5]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q    <= '0;
      tx_holding_q  <= '0;
      tx_primed_q   <= 1'b0;
      rx_shift_q    <= '0;
      rx_holding_q  <= '0;
      bitcnt_q      <= '0;
      roe_q         <= 1'b0;
      toe_q         <= 1'b0;
      tue_q         <= 1'b0;
      rrdy_q        <= 1'b0;
      ctrl_q        <= '0;
      rd_strobe_q   <= 1'b0;
      wr_strobe_q   <= 1'b0;
      data_to_cpu_q <= '0;
      irq_q         <= 1'b0;
    end else begin
      tx_shift_q    <= tx_shift_d;
      tx_holding_q  <= tx_holding_d;
      tx_primed_q   <= tx_primed_d;
      rx_shift_q    <= rx_shift_d;
      rx_holding_q  <= rx_holding_d;
      bitcnt_q      <= bitcnt_d;
      roe_q         <= roe_d;
      toe_q         <= toe_d;
      tue_q         <= tue_d;
      rrdy_q        <= rrdy_d;
      ctrl_q        <= ctrl_d;
      rd_strobe_q   <= rd_strobe_d;
      wr_strobe_q   <= wr_strobe_d;
      data_to_cpu_q <= data_to_cpu_d;
      irq_q         <= irq_d;
    end
  end

  assign MISO          = tx_shift_q[DATABITS-1];
  assign MISO_oe       = ss_act;
  assign data_to_cpu   = data_to_cpu_q;
  assign irq           = irq_q;
  assign dataavailable = rrdy_q;
  assign readyfordata  = trdy;

endmodule

// File: tb/tb_accel_spi_slave.sv
// Directed bench for accel_spi_slave: register reads and MISO bits are checked
// by monitors against queues of expected values filled by the stimulus.
module tb_accel_spi_slave;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        SCLK = 1'b0, SS_n = 1'b1, MOSI = 1'b0;
  logic        MISO, MISO_oe;
  logic [2:0]  mem_addr = 3'd0;
  logic [15:0] data_from_cpu = 16'h0;
  logic [15:0] data_to_cpu;
  logic        read_n = 1'b1, write_n = 1'b1, spi_select = 1'b0;
  logic        irq, dataavailable, readyfordata;

  int tests = 0;
  int fails = 0;

  string       rd_name[$];
  logic [15:0] rd_exp[$];
  logic        miso_exp[$];

  accel_spi_slave dut (
    .clk(clk), .reset_n(reset_n), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu),
    .read_n(read_n), .write_n(write_n), .spi_select(spi_select),
    .irq(irq), .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; write_n = 1'b0; mem_addr = a; data_from_cpu = d;
    idle(2);
    spi_select = 1'b0; write_n = 1'b1;
    idle(2);
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string nm);
    rd_name.push_back(nm);
    rd_exp.push_back(exp);
    @(negedge clk);
    spi_select = 1'b1; read_n = 1'b0; mem_addr = a;
    idle(2);
    spi_select = 1'b0; read_n = 1'b1;
    idle(2);
  endtask

  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = 0; i < n; i++) miso_exp.push_back(v[7-i]);
  endtask

  task automatic frame(input logic [7:0] m, input int n);
    for (int i = 0; i < n; i++) begin
      MOSI = m[7-i];
      idle(6);
      SCLK = 1'b1;
      idle(6);
      SCLK = 1'b0;
    end
    idle(6);
  endtask

  task automatic ss_low;
    @(negedge clk); SS_n = 1'b0; idle(8);
  endtask

  task automatic ss_high;
    @(negedge clk); SS_n = 1'b1; idle(8);
  endtask

  // Read monitor: data_to_cpu is compared just after the second access cycle.
  initial begin : rd_mon
    int rcnt;
    string nm;
    logic [15:0] e;
    rcnt = 0;
    forever begin
      @(posedge clk);
      if (spi_select && !read_n) rcnt++;
      else rcnt = 0;
      if (rcnt == 2) begin
        #1;
        tests++;
        if (rd_exp.size() == 0) begin
          fails++;
          $display("FAIL rd_unexpected: got 0x%h, expected no read", data_to_cpu);
        end else begin
          nm = rd_name.pop_front();
          e  = rd_exp.pop_front();
          if (data_to_cpu !== e) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, data_to_cpu, e);
          end
        end
      end
    end
  end

  // MISO monitor: master samples on each SCLK rise while selected.
  initial begin : miso_mon
    logic e;
    forever begin
      @(posedge SCLK);
      if (!SS_n) begin
        tests++;
        if (miso_exp.size() == 0) begin
          fails++;
          $display("FAIL miso_extra: got %b, expected no bit", MISO);
        end else begin
          e = miso_exp.pop_front();
          if (MISO !== e) begin
            fails++;
            $display("FAIL miso_bit: got %b, expected %b", MISO, e);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle(4);
    #1 chk("rst_miso", 16'(MISO), 16'h0);
    chk("rst_oe", 16'(MISO_oe), 16'h0);
    chk("rst_irq", 16'(irq), 16'h0);
    reset_n = 1'b1;
    idle(4);
    chk("rst_trdy", 16'(readyfordata), 16'h1);
    chk("rst_rrdy", 16'(dataavailable), 16'h0);
    rd(3'd2, 16'h0040, "rst_status");
    rd(3'd3, 16'h0000, "rst_ctrl");
    rd(3'd0, 16'h0000, "rst_rxdata");
    rd(3'd5, 16'h0000, "unmapped");

    // Basic frame: TX 0xA5, RX 0x3C, IRRDY enabled
    wr(3'd3, 16'h0080);
    rd(3'd3, 16'h0080, "t1_ctrl");
    wr(3'd1, 16'h00A5);
    chk("t1_trdy_low", 16'(readyfordata), 16'h0);
    rd(3'd2, 16'h0000, "t1_status_primed");
    push_bits(8'hA5, 8);
    ss_low;
    chk("t1_oe", 16'(MISO_oe), 16'h1);
    frame(8'h3C, 8);
    ss_high;
    chk("t1_rrdy", 16'(dataavailable), 16'h1);
    chk("t1_irq", 16'(irq), 16'h1);
    rd(3'd0, 16'h003C, "t1_rxdata");
    chk("t1_rrdy_clr", 16'(dataavailable), 16'h0);
    chk("t1_irq_clr", 16'(irq), 16'h0);
    rd(3'd2, 16'h0160, "t1_status_tue");
    wr(3'd2, 16'h0000);
    rd(3'd2, 16'h0040, "t1_status_clr");

    // Underrun with IE enabled
    wr(3'd3, 16'h0100);
    push_bits(8'h00, 8);
    ss_low;
    frame(8'h5A, 8);
    ss_high;
    chk("t2_irq_e", 16'(irq), 16'h1);
    rd(3'd2, 16'h01E0, "t2_status");
    wr(3'd2, 16'hFFFF);
    chk("t2_irq_clr", 16'(irq), 16'h0);
    rd(3'd2, 16'h00C0, "t2_status_clr");
    rd(3'd0, 16'h005A, "t2_rxdata");
    wr(3'd3, 16'h0000);

    // Back-to-back frames, overrun, TX refilled after each load
    wr(3'd1, 16'h0055);
    push_bits(8'h55, 8);
    push_bits(8'h66, 8);
    ss_low;
    wr(3'd1, 16'h0066);
    frame(8'h11, 8);
    wr(3'd1, 16'h0077);
    frame(8'h22, 8);
    ss_high;
    rd(3'd2, 16'h01C8, "t3_status_roe");
    rd(3'd0, 16'h0022, "t3_rxdata");
    wr(3'd2, 16'h0000);
    rd(3'd2, 16'h0040, "t3_status_clr");

    // TX overrun: second write dropped
    wr(3'd1, 16'h003A);
    wr(3'd1, 16'h00C3);
    rd(3'd2, 16'h0110, "t4_status_toe");
    push_bits(8'h3A, 8);
    ss_low;
    frame(8'hF0, 8);
    ss_high;
    rd(3'd2, 16'h01F0, "t4_status");
    rd(3'd0, 16'h00F0, "t4_rxdata");
    wr(3'd2, 16'h0000);

    // Abort after 5 bits, then a clean frame
    push_bits(8'h00, 5);
    ss_low;
    frame(8'hFF, 5);
    ss_high;
    chk("t5_no_rrdy", 16'(dataavailable), 16'h0);
    rd(3'd2, 16'h0160, "t5_status_abort");
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0042);
    push_bits(8'h42, 8);
    ss_low;
    frame(8'h81, 8);
    ss_high;
    rd(3'd2, 16'h01E0, "t5_status");
    rd(3'd0, 16'h0081, "t5_rxdata");
    wr(3'd2, 16'h0000);

    // Reset mid-frame
    wr(3'd3, 16'h0040);
    chk("t6_irq_trdy", 16'(irq), 16'h1);
    wr(3'd1, 16'h00FF);
    push_bits(8'hFF, 3);
    ss_low;
    frame(8'hE0, 3);
    chk("t6_miso_pre", 16'(MISO), 16'h1);
    chk("t6_oe_pre", 16'(MISO_oe), 16'h1);
    chk("t6_irq_pre", 16'(irq), 16'h1);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t6_miso_rst", 16'(MISO), 16'h0);
    chk("t6_oe_rst", 16'(MISO_oe), 16'h0);
    chk("t6_irq_rst", 16'(irq), 16'h0);
    SS_n = 1'b1;
    idle(4);
    reset_n = 1'b1;
    idle(4);
    rd(3'd2, 16'h0040, "t6_status");
    rd(3'd3, 16'h0000, "t6_ctrl");
    chk("t6_irq_after", 16'(irq), 16'h0);

    idle(4);
    chk("rd_queue_empty", 16'(rd_exp.size()), 16'h0);
    chk("miso_queue_empty", 16'(miso_exp.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/accel_spi_slave.md
Name: accel_spi_slave

Overview:
- SPI slave (target) endpoint with a memory-mapped CPU register port; the responder counterpart to the SPI master used on the accelerometer link.
- Lets a Nios-side subsystem act as the SPI device: in-system loopback against the master, and emulation of the accelerometer for bring-up.
- Mode fixed: CPOL=0, CPHA=0, MSB first.
- SCLK/SS_n/MOSI are oversampled in the clk domain; SPI pins are never used as clocks.

Parameters:
- DATABITS, 8, bits per SPI frame (1..16).
- SYNC_STAGES, 2, synchroniser flops on SCLK, SS_n and MOSI (>=2).
- TX_DEFAULT, 0, value shifted out when no TX byte is loaded (underrun).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset.
- SCLK  in  1  SPI clock from the master.
- SS_n  in  1  slave select, active low.
- MOSI  in  1  master-out data.
- MISO  out  1  slave-out data.
- MISO_oe  out  1  MISO output enable, 1 while SS_n is active (synchronised).
- mem_addr  in  3  register address.
- data_from_cpu  in  16  write data.
- data_to_cpu  out  16  registered read data.
- read_n  in  1  read request, active low.
- write_n  in  1  write request, active low.
- spi_select  in  1  chip select of the register port.
- irq  out  1  registered interrupt.
- dataavailable  out  1  equals RRDY.
- readyfordata  out  1  equals TRDY.

Interface: clock clk; reset reset_n, asynchronous, active-low.

Behaviour:
- Reset: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0. All status, control and holding registers are 0. Bit counter is 0. TRDY=1.
- Input synchronisation and edge detection:
  - SCLK, SS_n and MOSI each pass through SYNC_STAGES flops.
  - A further flop detects edges: sclk_rise, sclk_fall, ss_fall, ss_rise (one clk pulse each).
  - Pin-to-action latency is SYNC_STAGES+1 clk. The SCLK high/low time must be >=4 clk.
- Register port:
  - Two-cycle access. The first cycle latches a strobe (rd_strobe/wr_strobe, and a second cycle does not re-trigger).
  - Write effects apply on the registered strobe cycle.
  - data_to_cpu is registered and valid on the 2nd cycle.
- Register map:
  - 0 rxdata (r).
  - 1 txdata (w).
  - 2 status (r; any write clears ROE, TOE, TUE).
  - 3 control (r/w).
  - Other addresses read 0.
- Status bits: [3] ROE, [4] TOE, [5] TUE, [6] TRDY, [7] RRDY, [8] E=ROE|TOE|TUE, [9] BUSY (synchronised SS active).
- Control bits: [3] IROE, [4] ITOE, [5] ITUE, [6] ITRDY, [7] IRRDY, [8] IE.
- irq is registered: irq <= OR of each status flag ANDed with its enable, with IE qualifying E.
- TX path:
  - Single-entry tx_holding. TRDY = ~tx_primed.
  - Data write with TRDY=1: byte stored, tx_primed=1.
  - Data write with TRDY=0: data dropped, TOE=1.
- Shift-register load happens on ss_fall and on frame completion while SS remains active:
  - If tx_primed: tx_shift <= tx_holding, tx_primed=0.
  - Otherwise: tx_shift <= TX_DEFAULT, TUE=1.
- Load and CPU write in the same clk while primed: the load takes the old byte, the new byte is stored, tx_primed stays 1, no TOE.
- MISO = tx_shift[DATABITS-1].
- On sclk_fall with bitcnt != 0: tx_shift shifts left. A fall with bitcnt==0 does not shift, so the freshly loaded MSB holds for the first rising edge.
- RX path:
  - On sclk_rise: rx_shift <= {rx_shift, MOSI_sync}, bitcnt increments.
  - When bitcnt reaches DATABITS: bitcnt=0, rx_holding <= completed word, RRDY=1. ROE=1 if RRDY was already 1; rx_holding is overwritten.
- Data read (addr 0) clears RRDY on the 2nd cycle.
- Priorities: a hardware set wins over a same-cycle CPU clear (RRDY and error flags).
- Abort: ss_rise mid-frame clears bitcnt. The partial word is discarded with no RRDY. A TX byte already loaded is consumed, not restored.
- SCLK edges while SS_n is inactive are ignored.
- Reset asserted mid-frame returns all state to reset values immediately.

Test Plan:
- Write 0xA5 to txdata, master sends 0x3C in 8 clocks with SS_n low -> MISO bits 1,0,1,0,0,1,0,1; rxdata=0x3C; RRDY=1; irq=1 only if IRRDY=1; RRDY=0 after rxdata read.
- SS_n low with no txdata written -> MISO carries 0x00 (TX_DEFAULT), TUE=1, E=1; status write clears TUE.
- Two back-to-back frames 0x11, 0x22 without reading rxdata -> rxdata=0x22, ROE=1. With txdata 0x55 then 0x66 preloaded (second write after the first load) -> MISO sends 0x55 then 0x66, no TUE.
- Two txdata writes before any SS_n fall -> TOE=1; the first byte is transmitted.
- SS_n deasserted after 5 SCLK rises -> no RRDY; the next full frame 0x81 receives correctly as 0x81.
- reset_n pulsed low mid-frame -> MISO=0, MISO_oe=0, status=0x0040 (TRDY only), irq=0.
